// File: rtl/core_mc_hs.sv
// Multicycle RV32I/RV32E core with req/ack instruction and data ports.
// Ports: clk, rst (sync, active-high), imem_*, dmem_*, retire, halted, illegal.
module core_mc_hs #(
  parameter logic [31:0] START_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS     = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  localparam int AW   = (NUM_REGS == 16) ? 4 : 5;
  localparam bit RV32E = (NUM_REGS == 16);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  logic [31:0] rf [NUM_REGS];
  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic [31:0] res;
  logic [31:0] tgt_q;
  logic        take_q;
  logic        ireq;
  logic        dreq;
  logic        dwe;
  logic        ill;

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;

  logic op_ok;

  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: op_ok = 1'b1;
      is_jalr: op_ok = f3 == 3'd0;
      is_br: op_ok = f3 != 3'd2 && f3 != 3'd3;
      is_ld, is_st: op_ok = f3 == 3'd2;
      is_opi: begin
        if (f3 == 3'd1)
          op_ok = f7 == 7'h00;
        else if (f3 == 3'd5)
          op_ok = f7 == 7'h00 || f7 == 7'h20;
        else
          op_ok = 1'b1;
      end
      is_op: op_ok = f7 == 7'h00 ||
        (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      default: op_ok = 1'b0;
    endcase
  end

  // Only fields that really name registers are range-checked;
  // in U/J/S/B formats those bit positions hold immediates.
  logic use_rs1, use_rs2, wr_rd, bad_reg, bad;

  assign use_rs1 = !(is_lui || is_auipc || is_jal);
  assign use_rs2 = is_br || is_st || is_op;
  assign wr_rd   = is_lui || is_auipc || is_jal || is_jalr ||
                   is_ld || is_opi || is_op;
  assign bad_reg = RV32E && ((use_rs1 && rs1[4]) ||
                             (use_rs2 && rs2[4]) ||
                             (wr_rd && rd[4]));
  assign bad = !op_ok || bad_reg;

  logic [31:0] rd1, rd2;

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1[AW-1:0]];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2[AW-1:0]];

  logic [31:0] op_b, sum, alu, tgt;
  logic        cond, take;

  assign op_b = is_op ? rs2v : (is_st ? imm_s : imm_i);
  assign sum  = rs1v + op_b;

  always_comb begin
    alu = sum;
    if (is_lui)
      alu = imm_u;
    else if (is_auipc)
      alu = pc + imm_u;
    else if (is_jal || is_jalr)
      alu = pc + 32'd4;
    else if (is_op || is_opi) begin
      unique case (f3)
        3'd0: alu = (is_op && f7[5]) ? rs1v - op_b : sum;
        3'd1: alu = rs1v << op_b[4:0];
        3'd2: alu = {31'd0, $signed(rs1v) < $signed(op_b)};
        3'd3: alu = {31'd0, rs1v < op_b};
        3'd4: alu = rs1v ^ op_b;
        3'd5: alu = ir[30] ? 32'($signed(rs1v) >>> op_b[4:0])
                           : rs1v >> op_b[4:0];
        3'd6: alu = rs1v | op_b;
        default: alu = rs1v & op_b;
      endcase
    end
  end

  always_comb begin
    unique case (f3)
      3'd0: cond = rs1v == rs2v;
      3'd1: cond = rs1v != rs2v;
      3'd4: cond = $signed(rs1v) < $signed(rs2v);
      3'd5: cond = $signed(rs1v) >= $signed(rs2v);
      3'd6: cond = rs1v < rs2v;
      3'd7: cond = rs1v >= rs2v;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    tgt = pc + imm_b;
    if (is_jalr)
      tgt = sum & ~32'd1;
    else if (is_jal)
      tgt = pc + imm_j;
  end

  assign take = is_jal || is_jalr || (is_br && cond);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IF;
      pc     <= START_ADDR;
      ir     <= 32'd0;
      rs1v   <= 32'd0;
      rs2v   <= 32'd0;
      res    <= 32'd0;
      tgt_q  <= 32'd0;
      take_q <= 1'b0;
      ireq   <= 1'b0;
      dreq   <= 1'b0;
      dwe    <= 1'b0;
      ill    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= 32'd0;
    end else begin
      unique case (state)
        S_IF: begin
          // After reset the request rises one cycle late.
          if (!ireq)
            ireq <= 1'b1;
          else if (imem_ack) begin
            ir    <= imem_rdata;
            ireq  <= 1'b0;
            state <= S_ID;
          end
        end
        S_ID: begin
          if (HALT_ON_ZERO && ir == 32'd0)
            state <= S_HALT;
          else if (bad) begin
            ill   <= 1'b1;
            state <= S_HALT;
          end else begin
            rs1v  <= rd1;
            rs2v  <= rd2;
            state <= S_EX;
          end
        end
        S_EX: begin
          if (take && tgt[1]) begin
            ill   <= 1'b1;
            state <= S_HALT;
          end else begin
            res    <= alu;
            tgt_q  <= tgt;
            take_q <= take;
            if (is_ld || is_st) begin
              dreq  <= 1'b1;
              dwe   <= is_st;
              state <= S_MEM;
            end else
              state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dreq <= 1'b0;
            dwe  <= 1'b0;
            if (is_ld)
              res <= dmem_rdata;
            state <= S_WB;
          end
        end
        S_WB: begin
          if (wr_rd && rd != 5'd0)
            rf[rd[AW-1:0]] <= res;
          pc    <= take_q ? tgt_q : pc + 32'd4;
          ireq  <= 1'b1;
          state <= S_IF;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_req   = ireq;
  assign imem_addr  = pc;
  assign dmem_req   = dreq;
  assign dmem_we    = dwe;
  assign dmem_addr  = res;
  assign dmem_wdata = rs2v;
  assign retire     = state == S_WB;
  assign halted     = state == S_HALT;
  assign illegal    = ill;

endmodule
